// File: rtl/irda_pkg.sv
// Shared IrDA SIR definitions: FSM state encoding and default timing
// constants for a 50 MHz clock at 9600 baud.
package irda_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      WAIT  = 2'd2,
      GUARD = 2'd3
   } irda_state_e;

   // 50 MHz / 9600 baud, rounded to the nearest clock
   localparam int BIT_CYCLES_9600 = 5208;
   // 3/16 of a 9600 baud bit period, rounded to the nearest clock
   localparam int PULSE_3_16      = 977;
   // start + 8 data + stop
   localparam int FRAME_BITS_8N1  = 10;
   // one bit period of echo guard after the stop bit
   localparam int GUARD_9600      = 5208;
   // wide enough for BIT_CYCLES_9600 and GUARD_9600
   localparam int CNT_W_9600      = 14;

endpackage

// File: rtl/irda_bit_timer.sv
// Bit-period timer shared by the IrDA transmit and receive paths: one
// clearable/enabled up-counter with terminal-count flags for the end of
// the IR pulse, the end of a bit period and the end of the guard time.
module irda_bit_timer #(
   parameter int CNT_W        = 14,
   parameter int PULSE_CYCLES = 977,
   parameter int BIT_CYCLES   = 5208,
   parameter int GUARD_CYCLES = 5208
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic pulse_done,
   output logic bit_done,
   output logic guard_done
);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Clear wins over enable so a terminal count can restart the period
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Counter register, cleared by the active-low asynchronous reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign pulse_done = (count_q == PULSE_LAST);
   assign bit_done   = (count_q == BIT_LAST);
   assign guard_done = (count_q == GUARD_LAST);

endmodule

// File: rtl/irda_tx_modulator.sv
// IrDA SIR transmit modulator: turns each 0 bit of a UART frame into one
// short IR pulse and flags the frame plus a guard time on `sending` so the
// receiver can blank out the local optical echo.
module irda_tx_modulator
   import irda_pkg::*;
#(
   parameter int BIT_CYCLES   = BIT_CYCLES_9600,
   parameter int PULSE_CYCLES = PULSE_3_16,
   parameter int FRAME_BITS   = FRAME_BITS_8N1,
   parameter int GUARD_CYCLES = GUARD_9600,
   parameter int CNT_W        = CNT_W_9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tx_enable,
   input  logic       uart_tx_data,
   output logic       ir_tx_data,
   output logic       sending,
   output logic [3:0] bit_index
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   irda_state_e state_q;
   irda_state_e state_d;
   logic [3:0]  bit_index_q;
   logic [3:0]  bit_index_d;
   logic        ir_tx_data_q;
   logic        ir_tx_data_d;
   logic        sending_q;
   logic        sending_d;
   logic        sync_1_q;
   logic        sync_2_q;
   logic        line_s;
   logic        timer_clear;
   logic        timer_enable;
   logic        pulse_done;
   logic        bit_done;
   logic        guard_done;

   // Two-flop synchroniser for the asynchronous UART line; resets to the
   // idle-high level so reset never looks like a start bit
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_1_q <= 1'b1;
         sync_2_q <= 1'b1;
      end else begin
         sync_1_q <= uart_tx_data;
         sync_2_q <= sync_1_q;
      end
   end

   assign line_s = sync_2_q;

   // One counter spans PULSE and WAIT so every bit is exactly BIT_CYCLES long
   irda_bit_timer #(
      .CNT_W       (CNT_W),
      .PULSE_CYCLES(PULSE_CYCLES),
      .BIT_CYCLES  (BIT_CYCLES),
      .GUARD_CYCLES(GUARD_CYCLES)
   ) u_bit_timer (
      .clock     (clock),
      .reset     (reset),
      .clear     (timer_clear),
      .enable    (timer_enable),
      .pulse_done(pulse_done),
      .bit_done  (bit_done),
      .guard_done(guard_done)
   );

   // Next-state and next-output logic; outputs are computed one cycle
   // ahead so they leave the block straight from flops
   always_comb begin
      state_d      = state_q;
      bit_index_d  = bit_index_q;
      ir_tx_data_d = 1'b0;
      sending_d    = 1'b0;
      timer_clear  = 1'b0;
      timer_enable = 1'b0;
      if (!tx_enable) begin
         state_d     = IDLE;
         bit_index_d = '0;
         timer_clear = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               timer_clear = 1'b1;
               if (!line_s) begin
                  state_d      = PULSE;
                  bit_index_d  = '0;
                  ir_tx_data_d = 1'b1;
                  sending_d    = 1'b1;
               end
            end
            PULSE: begin
               timer_enable = 1'b1;
               sending_d    = 1'b1;
               ir_tx_data_d = 1'b1;
               if (pulse_done) begin
                  state_d      = WAIT;
                  ir_tx_data_d = 1'b0;
               end
            end
            WAIT: begin
               sending_d = 1'b1;
               if (bit_done) begin
                  timer_clear = 1'b1;
                  if (bit_index_q == LAST_BIT) begin
                     state_d = GUARD;
                  end else begin
                     bit_index_d = bit_index_q + 4'd1;
                     if (!line_s) begin
                        state_d      = PULSE;
                        ir_tx_data_d = 1'b1;
                     end
                  end
               end else begin
                  timer_enable = 1'b1;
               end
            end
            GUARD: begin
               sending_d = 1'b1;
               if (guard_done) begin
                  timer_clear = 1'b1;
                  state_d     = IDLE;
                  sending_d   = 1'b0;
               end else begin
                  timer_enable = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and registered-output flops
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_index_q  <= '0;
         ir_tx_data_q <= 1'b0;
         sending_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_index_q  <= bit_index_d;
         ir_tx_data_q <= ir_tx_data_d;
         sending_q    <= sending_d;
      end
   end

   assign ir_tx_data = ir_tx_data_q;
   assign sending    = sending_q;
   assign bit_index  = bit_index_q;

endmodule

// File: tb/tb_irda_tx_modulator.sv
// Self-checking bench for irda_tx_modulator using a frame-timeline model:
// a frame is "active" for FRAME_LEN+GRD cycles from its start, and the IR
// output is high in the first PUL cycles of every bit whose sampled value is 0.
module tb_irda_tx_modulator;

   localparam int BIT       = 16;
   localparam int PUL       = 3;
   localparam int FB        = 10;
   localparam int GRD       = 16;
   localparam int FRAME_LEN = FB * BIT;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tx_enable = 1'b1;
   logic       uart_tx_data = 1'b0;
   logic       ir_tx_data;
   logic       sending;
   logic [3:0] bit_index;

   int total = 0;
   int bad   = 0;

   // Reference model state: synchroniser delay line, frame activity,
   // cycle offset within the frame and the bit values seen at boundaries
   logic          m_s1;
   logic          m_s2;
   logic          m_active;
   logic          m_known;
   int            m_t;
   int            m_bidx;
   logic [FB-1:0] m_bits;

   irda_tx_modulator #(
      .BIT_CYCLES  (BIT),
      .PULSE_CYCLES(PUL),
      .FRAME_BITS  (FB),
      .GUARD_CYCLES(GRD),
      .CNT_W       (5)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .tx_enable   (tx_enable),
      .uart_tx_data(uart_tx_data),
      .ir_tx_data  (ir_tx_data),
      .sending     (sending),
      .bit_index   (bit_index)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_s1     = 1'b1;
      m_s2     = 1'b1;
      m_active = 1'b0;
      m_known  = 1'b1;
      m_t      = 0;
      m_bidx   = 0;
      m_bits   = '1;
   endtask

   // Advance the model by one clock edge using the inputs held since the last negedge
   task automatic model_step();
      logic ls;
      if (!reset) begin
         model_reset();
      end else begin
         ls   = m_s2;
         m_s2 = m_s1;
         m_s1 = uart_tx_data;
         if (!tx_enable) begin
            m_active = 1'b0;
            m_bidx   = 0;
            m_known  = 1'b1;
         end else if (!m_active) begin
            if (!ls) begin
               m_active  = 1'b1;
               m_t       = 0;
               m_bits[0] = 1'b0;
               m_bidx    = 0;
               m_known   = 1'b1;
            end
         end else begin
            m_t++;
            if (m_t == FRAME_LEN + GRD) begin
               m_active = 1'b0;
               m_known  = 1'b0;
            end else if (m_t < FRAME_LEN) begin
               if (m_t % BIT == 0) m_bits[m_t / BIT] = ls;
               m_bidx = m_t / BIT;
            end
         end
      end
   endtask

   // One clock: model step on the rising edge, compare on the falling edge
   task automatic tick();
      logic e_ir;
      @(posedge clock);
      model_step();
      @(negedge clock);
      e_ir = m_active && (m_t < FRAME_LEN) && ((m_t % BIT) < PUL) && !m_bits[m_t / BIT];
      check("ir_tx_data", int'(ir_tx_data), int'(e_ir));
      check("sending", int'(sending), int'(m_active));
      if (m_known) check("bit_index", int'(bit_index), m_bidx);
   endtask

   task automatic idle(input int n, output int ir_cycles);
      ir_cycles = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (ir_tx_data) ir_cycles++;
         uart_tx_data = 1'b1;
      end
   endtask

   // Drive one 10-bit frame (bit 0 first) and measure the pulse train.
   // abort_at / rst_at >= 0 inject a tx_enable drop or an async reset.
   task automatic run_frame(input logic [9:0] bits, input int abort_at, input int rst_at,
                            input int e_pulses, input int e_space, input int e_first);
      int   pulses = 0;
      int   first = -1;
      int   last = -1;
      int   sp_min = 1000000;
      int   sp_max = -1;
      int   w_cur = 0;
      int   w_min = 1000000;
      int   w_max = -1;
      int   send_cnt = 0;
      int   bidx_max = 0;
      logic prev = 1'b0;
      logic forced = 1'b0;
      for (int i = 0; i < FRAME_LEN + GRD + 12; i++) begin
         tick();
         if (ir_tx_data && !prev) begin
            pulses++;
            if (first < 0) first = i;
            if (last >= 0) begin
               if (i - last < sp_min) sp_min = i - last;
               if (i - last > sp_max) sp_max = i - last;
            end
            last  = i;
            w_cur = 0;
         end
         if (ir_tx_data) w_cur++;
         if (!ir_tx_data && prev) begin
            if (w_cur < w_min) w_min = w_cur;
            if (w_cur > w_max) w_max = w_cur;
         end
         if (sending) send_cnt++;
         if (int'(bit_index) > bidx_max) bidx_max = int'(bit_index);
         prev = ir_tx_data;
         if (i == abort_at) begin
            check("abort_pre_ir", int'(ir_tx_data), 1);
            check("abort_pre_bit_index", int'(bit_index), 4);
            tx_enable = 1'b0;
            forced    = 1'b1;
         end
         if (abort_at >= 0 && i == abort_at + 1) begin
            check("abort_ir", int'(ir_tx_data), 0);
            check("abort_sending", int'(sending), 0);
            check("abort_bit_index", int'(bit_index), 0);
         end
         if (i == rst_at) begin
            #2;
            reset = 1'b0;
            model_reset();
            #1;
            check("async_rst_ir", int'(ir_tx_data), 0);
            check("async_rst_sending", int'(sending), 0);
            check("async_rst_bit_index", int'(bit_index), 0);
            forced = 1'b1;
         end
         if (rst_at >= 0 && i == rst_at + 4) reset = 1'b1;
         uart_tx_data = (forced || i >= FRAME_LEN) ? 1'b1 : bits[i / BIT];
      end
      if (e_pulses >= 0) begin
         check("pulse_count", pulses, e_pulses);
         check("first_pulse_cycle", first, e_first);
         check("pulse_width_min", w_min, PUL);
         check("pulse_width_max", w_max, PUL);
         check("sending_cycles", send_cnt, FRAME_LEN + GRD);
         check("bit_index_max", bidx_max, 9);
         if (e_pulses > 1) begin
            check("pulse_spacing_min", sp_min, e_space);
            check("pulse_spacing_max", sp_max, e_space);
         end
      end
   endtask

   initial begin
      int   cnt;
      int   gap;
      logic [7:0] data;
      logic [9:0] fbits;
      logic line;

      model_reset();
      // Reset held with the line low: outputs must stay quiet
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_ir", int'(ir_tx_data), 0);
         check("rst_sending", int'(sending), 0);
         check("rst_bit_index", int'(bit_index), 0);
      end
      reset = 1'b1;
      // Line already low at release: a break frame, stop bit also pulses
      run_frame(10'h000, -1, -1, 10, 16, 2);

      run_frame({1'b1, 8'h55, 1'b0}, -1, -1, 5, 32, 3);
      run_frame({1'b1, 8'hFF, 1'b0}, -1, -1, 1, 0, 3);
      run_frame({1'b1, 8'h00, 1'b0}, -1, -1, 9, 16, 3);

      // Enable dropped in the second cycle of the bit-4 pulse
      run_frame({1'b1, 8'h00, 1'b0}, 3 + 4 * BIT + 1, -1, -1, 0, 0);
      tx_enable = 1'b1;
      idle(40, cnt);
      check("reenable_ir_cycles", cnt, 0);

      // Asynchronous reset in the WAIT part of bit 0, then a clean frame
      run_frame({1'b1, 8'hFF, 1'b0}, -1, 3 + 8, -1, 0, 0);
      idle(4, cnt);
      run_frame({1'b1, 8'h55, 1'b0}, -1, -1, 5, 32, 3);

      // Random frames with glitches, random gaps and occasional enable drops
      for (int f = 0; f < 25; f++) begin
         data  = 8'($urandom);
         fbits = {1'b1, data, 1'b0};
         gap   = int'($urandom_range(0, 60));
         for (int i = 0; i < FRAME_LEN + gap; i++) begin
            tick();
            line = (i < FRAME_LEN) ? fbits[i / BIT] : 1'b1;
            if ($urandom_range(0, 24) == 0) line = ~line;
            uart_tx_data = line;
            tx_enable    = ($urandom_range(0, 399) != 0);
         end
      end
      tx_enable    = 1'b1;
      uart_tx_data = 1'b1;
      idle(FRAME_LEN + GRD + 8, cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
